opb_register_simulink2ppc_capture: RTL and testbench
====================================================

// Module: opb_register_simulink2ppc_capture
// PURPOSE
//  OPB slave that returns user-logic (Simulink) data to the PowerPC, the read-back counterpart of the
//  PPC-to-user control registers. Captures a 32-bit word on a user valid strobe and holds it for
//  software reads. Also provides a sticky new-data flag and an overrun counter. Sits on the OPB
//  beside the other software registers and uses the same 256-byte address window.
// PARAMETERS
//  C_BASEADDR    32'h01060B00  first byte address of the slave window
//  C_HIGHADDR    32'h01060BFF  last byte address of the slave window
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex5"     target family (informational only)
// PORTS
//  OPB_Clk          in   1   single clock for the bus and user logic
//  OPB_Rst          in   1   asynchronous, active-low reset
//  OPB_ABus         in   32  address [0:31], big-endian bit order
//  OPB_BE           in   4   byte enables (ignored; full-word access only)
//  OPB_DBus         in   32  write data [0:31]
//  OPB_RNW          in   1   1=read, 0=write
//  OPB_select       in   1   master transfer request
//  OPB_seqAddr      in   1   sequential burst hint (ignored; every beat is acked separately)
//  Sl_DBus          out  32  read data [0:31]; all-zero whenever Sl_xferAck=0 (wired-OR bus)
//  Sl_xferAck       out  1   one-cycle transfer acknowledge
//  Sl_errAck        out  1   tied 0
//  Sl_retry         out  1   tied 0
//  Sl_toutSup       out  1   tied 0
//  user_data_in     in   32  [31:0] value from user logic
//  user_data_valid  in   1   capture strobe, same clock domain
// BEHAVIOUR
//  - Reset (OPB_Rst=0, async assert): data_reg=0, new_flag=0, ovr_cnt=0, FSM=IDLE,
//    Sl_DBus=0, Sl_xferAck=0.
//  - hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR); word = OPB_ABus[28:29].
//  - Register map (read): word0 = data_reg; word1 = {23'b0, ovr_cnt[7:0], new_flag};
//    word2 = timestamp (optional feature); word3 = 32'h0.
//  - Register map (write): a write to word1 with OPB_DBus[31]=1 clears ovr_cnt. All other writes are
//    acked with no effect.
//  - Bus FSM:
//    IDLE -> ACK on hit.
//    ACK: Sl_xferAck=1 for exactly one cycle; read data is registered in the same cycle. -> DESEL.
//    DESEL: Sl_xferAck=0; -> IDLE when OPB_select=0, else stays in DESEL.
//  - Latency: Sl_xferAck asserts in the 2nd cycle after OPB_select rises. No back-to-back ack
//    without deselect.
//  - Capture: when user_data_valid=1, data_reg <= user_data_in on the next edge and new_flag <= 1.
//    If new_flag was already 1, ovr_cnt <= ovr_cnt+1, saturating at 8'hFF.
//  - A read ack of word0 clears new_flag.
//  - Simultaneous valid and word0 read ack: the read returns the old data_reg; new_flag stays 1
//    (set wins); ovr_cnt unchanged.
//  - Simultaneous overrun increment and ovr_cnt clear write: clear wins; result is 0.
//  - Reset asserted mid-transfer: FSM returns to IDLE and no ack is issued; the master times out.
// CONFIGURATION
//  OPB_REG_S2P_TIMESTAMP_EN defined:
//    - Adds a free-running 32-bit cycle counter, reset to 0 and wrapping at 2^32.
//    - Its value is captured into ts_reg on each user_data_valid.
//    - word2 reads ts_reg.
//  OPB_REG_S2P_TIMESTAMP_EN undefined:
//    - No counter and no ts_reg are built.
//    - word2 reads 32'h0.
// TESTING
//  1. Reset, then read word0 and word1 -> both 32'h0; ack in the 2nd cycle after select;
//     Sl_DBus=0 outside the ack.
//  2. valid with 32'hDEADBEEF, read word1 -> 32'h1; read word0 -> 32'hDEADBEEF; read word1 -> 32'h0.
//  3. Three valids with no read -> word1=32'h5 (ovr=2, flag=1); write word1 data 32'h1 -> 32'h1.
//  4. 300 valids with no read -> ovr_cnt saturates at 8'hFF; word1=32'h1FF.
//  5. valid 32'h12345678 in the ack cycle of a word0 read -> read returns the old value; flag stays 1;
//     the next word0 read returns 32'h12345678.
//  6. Access to C_HIGHADDR+4 -> no ack, Sl_DBus=0. With TIMESTAMP_EN: valid at cycle N after reset
//     -> word2 reads N.

Source files
------------

// File: rtl/opb_register_simulink2ppc_capture.sv
// OPB slave returning user-logic data to the PPC: captures a word on a
// user strobe, with sticky new-data flag and saturating overrun counter.
// Params: C_BASEADDR/C_HIGHADDR window, C_OPB_AWIDTH/DWIDTH, C_FAMILY.
// Ports: OPB_* slave inputs, Sl_* slave outputs, user_data_in/valid.
// Word map: 0 data, 1 {ovr_cnt,new_flag}, 2 timestamp, 3 zero.
// Optional: OPB_REG_S2P_TIMESTAMP_EN adds a cycle counter read at word2.
module opb_register_simulink2ppc_capture #(
  parameter logic [31:0] C_BASEADDR   = 32'h01060B00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01060BFF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  typedef enum logic [1:0] {IDLE, ACK, DESEL} state_t;

  localparam bit unused_family = (C_FAMILY != "");

  state_t      state;
  logic [1:0]  acc_word;
  logic        acc_rnw;
  logic [31:0] data_reg;
  logic        new_flag;
  logic [7:0]  ovr_cnt;
  logic [31:0] rdata;
  logic [1:0]  word;
  logic        hit;
  logic        rd0_done;
  logic        ovr_clr;
  logic        unused_ok;

  assign unused_ok = ^{OPB_BE, OPB_seqAddr,
                       OPB_DBus[0:C_OPB_DWIDTH-2]};

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign word = OPB_ABus[28:29];
  assign hit  = OPB_select
             && (OPB_ABus >= C_BASEADDR)
             && (OPB_ABus <= C_HIGHADDR);

  // Side effects land at the end of the ack cycle, so a strobe in that
  // cycle coincides with them while the read data is already registered.
  assign rd0_done = (state == ACK) && acc_rnw
                 && (acc_word == 2'd0);
  assign ovr_clr  = (state == ACK) && !acc_rnw
                 && (acc_word == 2'd1) && OPB_DBus[C_OPB_DWIDTH-1];

`ifdef OPB_REG_S2P_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_reg;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      ts_cnt <= '0;
      ts_reg <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (user_data_valid) ts_reg <= ts_cnt;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    unique case (word)
      2'd0: rdata = data_reg;
      2'd1: rdata = {23'b0, ovr_cnt, new_flag};
`ifdef OPB_REG_S2P_TIMESTAMP_EN
      2'd2: rdata = ts_reg;
`else
      2'd2: rdata = '0;
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state      <= IDLE;
      Sl_xferAck <= 1'b0;
      Sl_DBus    <= '0;
      acc_word   <= '0;
      acc_rnw    <= 1'b0;
    end else begin
      Sl_xferAck <= 1'b0;
      Sl_DBus    <= '0;
      unique case (state)
        IDLE: if (hit) begin
          state      <= ACK;
          Sl_xferAck <= 1'b1;
          Sl_DBus    <= OPB_RNW ? rdata : '0;
          acc_word   <= word;
          acc_rnw    <= OPB_RNW;
        end
        ACK: state <= DESEL;
        DESEL: if (!OPB_select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A strobe coinciding with a word0 read keeps the flag set and is not
  // an overrun: the read consumed the previous word.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      data_reg <= '0;
      new_flag <= 1'b0;
      ovr_cnt  <= '0;
    end else begin
      if (user_data_valid) begin
        data_reg <= user_data_in;
        new_flag <= 1'b1;
      end else if (rd0_done) begin
        new_flag <= 1'b0;
      end
      if (ovr_clr)
        ovr_cnt <= '0;
      else if (user_data_valid && new_flag && !rd0_done
               && (ovr_cnt != 8'hFF))
        ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_opb_register_simulink2ppc_capture.sv
// Scoreboard bench for opb_register_simulink2ppc_capture.
// Stimulus queues expected read data; a negedge monitor checks acks.
module tb_opb_register_simulink2ppc_capture;

  localparam logic [31:0] BASE = 32'h01060B00;
  localparam logic [31:0] HIGH = 32'h01060BFF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b0;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = 4'hF;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in = '0;
  logic        user_data_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  opb_register_simulink2ppc_capture dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus),
    .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW),
    .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup), .user_data_in(user_data_in),
    .user_data_valid(user_data_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  always @(posedge OPB_Clk or negedge OPB_Rst)
    if (!OPB_Rst) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge OPB_Clk) begin
    logic [31:0] e;
    string       n;
    if (OPB_Rst) begin
      checks++;
      if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
        errors++;
        $display("FAIL tied_low got %b want 000",
                 {Sl_errAck, Sl_retry, Sl_toutSup});
      end
      if (Sl_xferAck) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got data %h", Sl_DBus);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (Sl_DBus !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, Sl_DBus, e);
          end
        end
      end else begin
        checks++;
        if (Sl_DBus !== 32'h0) begin
          errors++;
          $display("FAIL dbus_idle got %h want 0", Sl_DBus);
        end
      end
    end
  end

  task automatic access(input logic [31:0] addr, input bit rnw,
                        input logic [31:0] wdata, input bit exp_ack,
                        input logic [31:0] exp_data, input string nm,
                        input bit strobe, input logic [31:0] sdata);
    int n;
    bit got;
    logic [31:0] d;
    string s;
    n = 0;
    got = 1'b0;
    @(posedge OPB_Clk); #1;
    OPB_ABus = addr;
    OPB_RNW = rnw;
    OPB_DBus = wdata;
    OPB_select = 1'b1;
    if (exp_ack) begin
      exp_q.push_back(exp_data);
      name_q.push_back(nm);
    end
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck) begin
        got = 1'b1;
        n = i;
      end
    end
    if (got && strobe) begin
      user_data_in = sdata;
      user_data_valid = 1'b1;
    end
    OPB_select = 1'b0;
    checks++;
    if (exp_ack && (!got || n != 1)) begin
      errors++;
      $display("FAIL %s_latency got %0d edges (acked %0b) want 1",
               nm, n, got);
      if (!got && exp_q.size() != 0) begin
        d = exp_q.pop_back();
        s = name_q.pop_back();
      end
    end else if (!exp_ack && got) begin
      errors++;
      $display("FAIL %s_noack got ack want none", nm);
    end
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b0;
    @(posedge OPB_Clk); #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] e,
                    input string nm);
    access(addr, 1'b1, 32'h0, 1'b1, e, nm, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] w,
                    input string nm);
    access(addr, 1'b0, w, 1'b1, 32'h0, nm, 1'b0, 32'h0);
  endtask

  task automatic strobe(input logic [31:0] d, output int at);
    @(posedge OPB_Clk); #1;
    at = cyc;
    user_data_in = d;
    user_data_valid = 1'b1;
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b0;
  endtask

  initial begin
    int t;
    int ts;
    logic [31:0] ts_exp;
    repeat (3) @(posedge OPB_Clk);
    #1 OPB_Rst = 1'b1;

    rd(BASE + 32'h0, 32'h0, "reset_w0");
    rd(BASE + 32'h4, 32'h0, "reset_w1");

    strobe(32'hDEADBEEF, t);
    rd(BASE + 32'h4, 32'h1, "flag_set");
    rd(BASE + 32'h0, 32'hDEADBEEF, "data_w0");
    rd(BASE + 32'h4, 32'h0, "flag_clr");

    strobe(32'h1, t);
    strobe(32'h2, t);
    strobe(32'h3, t);
    rd(BASE + 32'h4, 32'h5, "ovr2");
    wr(BASE + 32'h4, 32'h1, "wr_clr");
    rd(BASE + 32'h4, 32'h1, "ovr_cleared");

    @(posedge OPB_Clk); #1;
    user_data_in = 32'hCAFEF00D;
    user_data_valid = 1'b1;
    repeat (300) @(posedge OPB_Clk);
    #1 user_data_valid = 1'b0;
    rd(BASE + 32'h4, 32'h1FF, "ovr_sat");

    wr(BASE + 32'h4, 32'h1, "wr_clr2");
    access(BASE + 32'h0, 1'b1, 32'h0, 1'b1, 32'hCAFEF00D,
           "coinc_old", 1'b1, 32'h12345678);
    rd(BASE + 32'h4, 32'h1, "coinc_flag");
    rd(BASE + 32'h0, 32'h12345678, "coinc_new");
    rd(BASE + 32'h4, 32'h0, "coinc_after");

    strobe(32'h55, t);
    strobe(32'h66, t);
    rd(BASE + 32'h4, 32'h3, "ovr1");
    access(BASE + 32'h4, 1'b0, 32'h1, 1'b1, 32'h0,
           "clr_vs_inc", 1'b1, 32'h77);
    rd(BASE + 32'h4, 32'h1, "clr_wins");

    strobe(32'h88, t);
    wr(BASE + 32'h4, 32'hFFFFFFFE, "wr_noclr");
    rd(BASE + 32'h4, 32'h3, "noclr_kept");
    wr(BASE + 32'h0, 32'hFFFFFFFF, "wr_w0");
    rd(BASE + 32'h0, 32'h88, "w0_unchanged");

    rd(BASE + 32'hC, 32'h0, "w3_zero");
    rd(HIGH - 32'h3, 32'h0, "high_word");
    access(HIGH + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0,
           "miss_high", 1'b0, 32'h0);
    access(BASE - 32'h4, 1'b1, 32'h0, 1'b0, 32'h0,
           "miss_low", 1'b0, 32'h0);

    strobe(32'hABCD0123, ts);
`ifdef OPB_REG_S2P_TIMESTAMP_EN
    ts_exp = 32'(ts);
`else
    ts_exp = 32'h0;
`endif
    rd(BASE + 32'h8, ts_exp, "w2_ts");

    repeat (3) @(posedge OPB_Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
